stopwatch_counter: RTL



---
 rtl/stopwatch_pkg.sv | 34 +++
 rtl/bcd_to_sseg.sv | 27 ++
 rtl/stopwatch_counter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state encoding, seven-segment glyphs and BCD helpers
// for the stopwatch_counter slice.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef logic [3:0] bcd_t;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    localparam bcd_t BCD_MAX = 4'd9;

    // Force a switch nibble into the 0..9 range
    function automatic bcd_t bcd_clamp(input logic [3:0] n);
        return (n > BCD_MAX) ? BCD_MAX : n;
    endfunction

endpackage

// File: rtl/bcd_to_sseg.sv
// bcd_to_sseg: one BCD digit to an active-low seven-segment code; codes
// above 9 show a blank digit.
module bcd_to_sseg
    import stopwatch_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    // Glyph lookup
    always_comb begin
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/stopwatch_counter.sv
// stopwatch_counter: SS.hh stopwatch / countdown timer with four
// seven-segment digit outputs. A prescaler divides clk down to one
// hundredth-second tick while running.
// Optional macro LEADING_ZERO_BLANK_EN blanks seg3 when the tens-of-seconds
// digit is 0.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 100_000_000,
    parameter int unsigned TICK_HZ = 100
)
(
    input  logic       clk,
    input  logic       resetload,
    input  logic       start,
    input  logic       load,
    input  logic       mode,
    input  logic [7:0] preset,
    output logic [6:0] seg0,
    output logic [6:0] seg1,
    output logic [6:0] seg2,
    output logic [6:0] seg3,
    output logic       running,
    output logic       done
);

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned PW  = $clog2(DIV);

    state_t            r_state;
    logic [3:0][3:0]   r_dig;      // [0]=hundredths ... [3]=tens of seconds
    logic [PW-1:0]     r_presc;

    logic [3:0][3:0]   w_nxt;
    logic              w_carry;
    logic              w_tick;
    logic              w_term_now;
    logic              w_term_nxt;
    logic [6:0]        w_seg3;

    assign w_tick = (r_presc == PW'(DIV - 1));

    // Next value on a tick: ripple carry (up) or borrow (down) from d0 upward
    always_comb begin
        w_nxt   = r_dig;
        w_carry = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            if (w_carry) begin
                if (!mode) begin
                    if (r_dig[i] == BCD_MAX) begin
                        w_nxt[i] = '0;
                    end else begin
                        w_nxt[i] = r_dig[i] + 4'd1;
                        w_carry  = 1'b0;
                    end
                end else begin
                    if (r_dig[i] == 4'd0) begin
                        w_nxt[i] = BCD_MAX;
                    end else begin
                        w_nxt[i] = r_dig[i] - 4'd1;
                        w_carry  = 1'b0;
                    end
                end
            end
        end
    end

    // Terminal value for the current direction, on the held and the next count
    always_comb begin
        w_term_now = mode ? (r_dig == '0) : (r_dig == {4{BCD_MAX}});
        w_term_nxt = mode ? (w_nxt == '0) : (w_nxt == {4{BCD_MAX}});
    end

    // Control FSM, prescaler and digit registers; load overrides everything
    always_ff @(posedge clk or posedge resetload) begin
        if (resetload) begin
            r_state <= ST_IDLE;
            r_dig   <= '0;
            r_presc <= '0;
        end else if (load) begin
            r_state <= ST_IDLE;
            r_dig   <= {bcd_clamp(preset[7:4]), bcd_clamp(preset[3:0]), 4'd0, 4'd0};
            r_presc <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_PAUSE: begin
                    if (start) begin
                        r_state <= w_term_now ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    // a pause request freezes the prescaler in the same cycle
                    if (start) begin
                        r_state <= ST_PAUSE;
                    end else if (w_tick) begin
                        r_presc <= '0;
                        r_dig   <= w_nxt;
                        if (w_term_nxt) begin
                            r_state <= ST_DONE;
                        end
                    end else begin
                        r_presc <= r_presc + PW'(1);
                    end
                end
                default: begin
                    r_state <= ST_DONE;
                end
            endcase
        end
    end

    assign running = (r_state == ST_RUN);
    assign done    = (r_state == ST_DONE);

    bcd_to_sseg u_seg0 (.i_bcd(r_dig[0]), .o_seg(seg0));
    bcd_to_sseg u_seg1 (.i_bcd(r_dig[1]), .o_seg(seg1));
    bcd_to_sseg u_seg2 (.i_bcd(r_dig[2]), .o_seg(seg2));
    bcd_to_sseg u_seg3 (.i_bcd(r_dig[3]), .o_seg(w_seg3));

`ifdef LEADING_ZERO_BLANK_EN
    assign seg3 = (r_dig[3] == 4'd0) ? SEG_BLANK : w_seg3;
`else
    assign seg3 = w_seg3;
`endif

endmodule
